// File: rtl/hazard_forward_ctrl_if.sv
// rtl/hazard_forward_ctrl_if.sv - ID-stage operand/hazard bundle between datapath and hazard_forward_ctrl
interface hazard_forward_ctrl_if #(
   parameter int REG_AW = 5
);
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic              id_rs_used;
   logic              id_rt_used;
   logic [REG_AW-1:0] id_dest;
   logic              id_reg_write;
   logic              id_load;
   logic              mem_wait;
   logic [1:0]        fwd_a_sel;
   logic [1:0]        fwd_b_sel;
   logic              pc_ld;
   logic              ifid_ld;
   logic              idex_bubble;
   logic              stall;

   modport master (
      output id_rs, id_rt, id_rs_used, id_rt_used, id_dest, id_reg_write, id_load, mem_wait,
      input  fwd_a_sel, fwd_b_sel, pc_ld, ifid_ld, idex_bubble, stall
   );

   modport slave (
      input  id_rs, id_rt, id_rs_used, id_rt_used, id_dest, id_reg_write, id_load, mem_wait,
      output fwd_a_sel, fwd_b_sel, pc_ld, ifid_ld, idex_bubble, stall
   );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// rtl/hazard_forward_ctrl.sv - 5-stage MIPS hazard/forwarding controller (EX/MEM/WB dest trackers)
// Optional stall/freeze counters enabled by defining HAZ_STALL_CNT_EN.
module hazard_forward_ctrl #(
   parameter int REG_AW   = 5,
   parameter int NUM_REGS = 32
) (
   input  logic                  clk,
   input  logic                  reset,
`ifdef HAZ_STALL_CNT_EN
   output logic [31:0]           stall_cnt,
   output logic [31:0]           freeze_cnt,
`endif
   hazard_forward_ctrl_if.slave  bus
);

   logic [REG_AW-1:0] ex_dest, mem_dest, wb_dest;
   logic              ex_rw, mem_rw, wb_rw;
   logic              ex_load, mem_load;
   logic              load_use;

   // Register 0 is hardwired zero, so it never creates a dependency.
   function automatic logic reg_live(input logic [REG_AW-1:0] r);
      return (r != '0) && ({1'b0, r} < (REG_AW + 1)'(NUM_REGS));
   endfunction

   function automatic logic [1:0] fwd_sel(
      input logic [REG_AW-1:0] src,
      input logic              used,
      input logic [REG_AW-1:0] e_dest,
      input logic              e_rw,
      input logic              e_load,
      input logic [REG_AW-1:0] m_dest,
      input logic              m_rw,
      input logic [REG_AW-1:0] w_dest,
      input logic              w_rw
   );
      logic [1:0] sel;
      sel = 2'b00;
      if (used && reg_live(src)) begin
         if (e_rw && e_dest == src)
            sel = e_load ? 2'b00 : 2'b01;
         else if (m_rw && m_dest == src)
            sel = 2'b10;
         else if (w_rw && w_dest == src)
            sel = 2'b11;
      end
      return sel;
   endfunction

   always_comb begin
      load_use = 1'b0;
      if (ex_load && ex_rw && reg_live(ex_dest))
         load_use = (bus.id_rs_used && bus.id_rs == ex_dest) ||
                    (bus.id_rt_used && bus.id_rt == ex_dest);
   end

   always_comb begin
      bus.pc_ld       = 1'b1;
      bus.ifid_ld     = 1'b1;
      bus.idex_bubble = 1'b0;
      bus.stall       = 1'b0;
      bus.fwd_a_sel   = fwd_sel(bus.id_rs, bus.id_rs_used, ex_dest, ex_rw, ex_load,
                                mem_dest, mem_rw, wb_dest, wb_rw);
      bus.fwd_b_sel   = fwd_sel(bus.id_rt, bus.id_rt_used, ex_dest, ex_rw, ex_load,
                                mem_dest, mem_rw, wb_dest, wb_rw);
      if (reset) begin
         bus.pc_ld       = 1'b0;
         bus.ifid_ld     = 1'b0;
         bus.idex_bubble = 1'b1;
         bus.fwd_a_sel   = 2'b00;
         bus.fwd_b_sel   = 2'b00;
      end else if (bus.mem_wait) begin
         // Freeze: hold everything, do not inject a bubble.
         bus.pc_ld   = 1'b0;
         bus.ifid_ld = 1'b0;
      end else if (load_use) begin
         bus.pc_ld       = 1'b0;
         bus.ifid_ld     = 1'b0;
         bus.idex_bubble = 1'b1;
         bus.stall       = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_dest  <= '0;
         ex_rw    <= 1'b0;
         ex_load  <= 1'b0;
         mem_dest <= '0;
         mem_rw   <= 1'b0;
         mem_load <= 1'b0;
         wb_dest  <= '0;
         wb_rw    <= 1'b0;
      end else if (!bus.mem_wait) begin
         wb_dest  <= mem_dest;
         wb_rw    <= mem_rw;
         mem_dest <= ex_dest;
         mem_rw   <= ex_rw;
         mem_load <= ex_load;
         if (load_use) begin
            ex_dest <= '0;
            ex_rw   <= 1'b0;
            ex_load <= 1'b0;
         end else begin
            ex_dest <= bus.id_dest;
            ex_rw   <= bus.id_reg_write;
            ex_load <= bus.id_load;
         end
      end
   end

`ifdef HAZ_STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt  <= '0;
         freeze_cnt <= '0;
      end else begin
         if (bus.stall && stall_cnt != 32'hFFFF_FFFF)
            stall_cnt <= stall_cnt + 32'd1;
         if (bus.mem_wait && freeze_cnt != 32'hFFFF_FFFF)
            freeze_cnt <= freeze_cnt + 32'd1;
      end
   end
`endif

   // mem_load is kept for tracker symmetry; the WB slot never needs it.
   logic unused_mem_load;
   assign unused_mem_load = mem_load;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb/tb_hazard_forward_ctrl.sv - directed + random bench for hazard_forward_ctrl against a pipeline-history model
module tb_hazard_forward_ctrl;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   hazard_forward_ctrl_if #(.REG_AW(5)) bus ();

`ifdef HAZ_STALL_CNT_EN
   logic [31:0] stall_cnt;
   logic [31:0] freeze_cnt;
   logic [31:0] m_stall_cnt;
   logic [31:0] m_freeze_cnt;
`endif

   hazard_forward_ctrl #(.REG_AW(5), .NUM_REGS(32)) dut (
      .clk        (clk),
      .reset      (reset),
`ifdef HAZ_STALL_CNT_EN
      .stall_cnt  (stall_cnt),
      .freeze_cnt (freeze_cnt),
`endif
      .bus        (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // History of the last three instructions issued past ID: [0]=EX, [1]=MEM, [2]=WB.
   typedef struct {
      logic [4:0] dest;
      logic       rw;
      logic       ld;
   } slot_t;

   slot_t pipe [3];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] model_sel(input logic [4:0] src, input logic used);
      if (!used || src == 5'd0) return 2'b00;
      for (int k = 0; k < 3; k++) begin
         if (pipe[k].rw && pipe[k].dest == src) begin
            if (k == 0 && pipe[k].ld) return 2'b00;
            return 2'(k + 1);
         end
      end
      return 2'b00;
   endfunction

   task automatic step(input logic rst, input logic [4:0] rs, input logic rsu,
                       input logic [4:0] rt, input logic rtu, input logic [4:0] dest,
                       input logic rw, input logic ld, input logic mw);
      logic lu;
      logic e_pc, e_bub, e_stall;
      logic [1:0] e_a, e_b;
      reset            = rst;
      bus.id_rs        = rs;
      bus.id_rs_used   = rsu;
      bus.id_rt        = rt;
      bus.id_rt_used   = rtu;
      bus.id_dest      = dest;
      bus.id_reg_write = rw;
      bus.id_load      = ld;
      bus.mem_wait     = mw;
      @(negedge clk);
      lu = pipe[0].ld && pipe[0].rw && pipe[0].dest != 5'd0 &&
           ((rsu && rs == pipe[0].dest) || (rtu && rt == pipe[0].dest));
      if (rst) begin
         e_pc = 1'b0; e_bub = 1'b1; e_stall = 1'b0; e_a = 2'b00; e_b = 2'b00;
      end else begin
         e_a = model_sel(rs, rsu);
         e_b = model_sel(rt, rtu);
         e_pc    = !(mw || lu);
         e_bub   = !mw && lu;
         e_stall = !mw && lu;
      end
      check("pc_ld", 32'(bus.pc_ld), 32'(e_pc));
      check("ifid_ld", 32'(bus.ifid_ld), 32'(e_pc));
      check("idex_bubble", 32'(bus.idex_bubble), 32'(e_bub));
      check("stall", 32'(bus.stall), 32'(e_stall));
      check("fwd_a_sel", 32'(bus.fwd_a_sel), 32'(e_a));
      check("fwd_b_sel", 32'(bus.fwd_b_sel), 32'(e_b));
`ifdef HAZ_STALL_CNT_EN
      check("stall_cnt", stall_cnt, m_stall_cnt);
      check("freeze_cnt", freeze_cnt, m_freeze_cnt);
`endif
      @(posedge clk);
      if (rst) begin
         for (int k = 0; k < 3; k++) pipe[k] = '{dest: 5'd0, rw: 1'b0, ld: 1'b0};
`ifdef HAZ_STALL_CNT_EN
         m_stall_cnt  = 32'd0;
         m_freeze_cnt = 32'd0;
`endif
      end else begin
`ifdef HAZ_STALL_CNT_EN
         if (e_stall) m_stall_cnt = m_stall_cnt + 32'd1;
         if (mw) m_freeze_cnt = m_freeze_cnt + 32'd1;
`endif
         if (!mw) begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (lu) pipe[0] = '{dest: 5'd0, rw: 1'b0, ld: 1'b0};
            else    pipe[0] = '{dest: dest, rw: rw, ld: ld};
         end
      end
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      for (int k = 0; k < 3; k++) pipe[k] = '{dest: 5'd0, rw: 1'b0, ld: 1'b0};
`ifdef HAZ_STALL_CNT_EN
      m_stall_cnt  = 32'd0;
      m_freeze_cnt = 32'd0;
`endif
      reset = 1'b1;
      bus.id_rs = '0; bus.id_rt = '0; bus.id_rs_used = 1'b0; bus.id_rt_used = 1'b0;
      bus.id_dest = '0; bus.id_reg_write = 1'b0; bus.id_load = 1'b0; bus.mem_wait = 1'b0;
      @(posedge clk);
      #1;

      // Reset, then idle.
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("idle_pc_ld_after_reset", 32'(bus.pc_ld), 32'd1);

      // ADD r5 then readers at distance 1, 2, 3.
      step(0, 0, 0, 0, 0, 5, 1, 0, 0);
      step(0, 5, 1, 0, 0, 0, 0, 0, 0);
      step(0, 5, 1, 0, 0, 0, 0, 0, 0);
      step(0, 5, 1, 0, 0, 0, 0, 0, 0);

      // LW r8, then rt=8 reader: one stall then MEM forward.
      step(0, 0, 0, 0, 0, 8, 1, 1, 0);
      step(0, 0, 0, 8, 1, 0, 0, 0, 0);
      step(0, 0, 0, 8, 1, 0, 0, 0, 0);

      // r0 never forwards; youngest producer of r3 wins.
      step(0, 0, 0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 3, 1, 0, 0);
      step(0, 0, 0, 0, 0, 3, 1, 0, 0);
      step(0, 3, 1, 3, 1, 0, 0, 0, 0);

      // Pending load-use frozen by mem_wait for 3 cycles.
      step(0, 0, 0, 0, 0, 9, 1, 1, 0);
      step(0, 9, 1, 0, 0, 0, 0, 0, 1);
      step(0, 9, 1, 0, 0, 0, 0, 0, 1);
      step(0, 9, 1, 0, 0, 0, 0, 0, 1);
`ifdef HAZ_STALL_CNT_EN
      check("freeze_cnt_after_3", freeze_cnt, 32'd3);
`endif
      step(0, 9, 1, 0, 0, 0, 0, 0, 0);
      step(0, 9, 1, 0, 0, 0, 0, 0, 0);
`ifdef HAZ_STALL_CNT_EN
      check("stall_cnt_after_freeze", stall_cnt, 32'd2);
`endif

      // Reset during a stall cycle clears everything.
      step(0, 0, 0, 0, 0, 4, 1, 1, 0);
      step(0, 4, 1, 0, 0, 0, 0, 0, 0);
      step(0, 4, 1, 0, 0, 0, 0, 0, 0);
      step(0, 4, 1, 0, 0, 4, 1, 1, 0);
      step(1, 4, 1, 0, 0, 0, 0, 0, 0);
      step(0, 4, 1, 4, 1, 0, 0, 0, 0);
      check("no_stall_after_reset", 32'(bus.stall), 32'd0);

      // Random traffic over a small register window to force collisions.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 49) == 0),
              5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
